// File: rtl/cmd_parser.sv
// Command frame parser: turns 8-byte USB OUT frames into a command handshake
// and returns a 4-byte status/data response on the USB IN stream.
module cmd_parser #(
  parameter int unsigned WR_WAIT = 64,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        areset_n,
  input  logic        cmd_clk,
  input  logic        cmd_rst,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  input  logic [7:0]  s_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic [7:0]  m_tdata,
  output logic        cmd_vld_o,
  output logic        cmd_ack_o,
  output logic        cmd_dir_o,
  output logic [1:0]  cmd_cmd_o,
  output logic [3:0]  cmd_tag_o,
  output logic [3:0]  cmd_lun_o,
  output logic [15:0] cmd_val_o,
  output logic [27:0] cmd_adr_o,
  input  logic        cmd_rdy_i,
  input  logic        cmd_err_i,
  input  logic [15:0] cmd_val_i
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned FRAME_W = 55;
  localparam logic [7:0]       MARKER   = 8'hA5;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(7);
  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_WAIT - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0] ST_OK  = 3'b001;
  localparam logic [2:0] ST_ERR = 3'b010;
  localparam logic [2:0] ST_TMO = 3'b100;

  typedef enum logic [1:0] {RECV, DROP, ISSUE, SEND} state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [CNT_W-1:0]     cnt;
  // Bytes 0..6 shift in oldest-first; the reserved bit of byte0 falls off the top.
  logic [FRAME_W-1:0]   frame;
  logic [15:0]          rdata;
  logic                 beat_c;
  logic [2:0]           status_c;

  assign beat_c = s_tvalid && s_tready;

  // Issue completion priority: error, read data, write wait expiry, timeout.
  always_comb begin
    status_c = 3'b000;
    if (cmd_err_i)                       status_c = ST_ERR;
    else if (cmd_dir_o && cmd_rdy_i)     status_c = ST_OK;
    else if (!cmd_dir_o && cnt == WR_LAST) status_c = ST_OK;
    else if (cnt == TMO_LAST)            status_c = ST_TMO;
  end

  always_ff @(posedge cmd_clk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= RECV;
      idx       <= '0;
      cnt       <= '0;
      frame     <= '0;
      rdata     <= '0;
      s_tready  <= 1'b0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      m_tdata   <= '0;
      cmd_vld_o <= 1'b0;
      cmd_ack_o <= 1'b0;
      cmd_dir_o <= 1'b0;
      cmd_cmd_o <= '0;
      cmd_tag_o <= '0;
      cmd_lun_o <= '0;
      cmd_val_o <= '0;
      cmd_adr_o <= '0;
    end else if (cmd_rst) begin
      state     <= RECV;
      idx       <= '0;
      cnt       <= '0;
      frame     <= '0;
      rdata     <= '0;
      s_tready  <= 1'b0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      m_tdata   <= '0;
      cmd_vld_o <= 1'b0;
      cmd_ack_o <= 1'b0;
      cmd_dir_o <= 1'b0;
      cmd_cmd_o <= '0;
      cmd_tag_o <= '0;
      cmd_lun_o <= '0;
      cmd_val_o <= '0;
      cmd_adr_o <= '0;
    end else begin
      cmd_ack_o <= 1'b0;
      case (state)
        RECV: begin
          s_tready <= 1'b1;
          if (beat_c) begin
            if (idx == IDX_LAST) begin
              idx <= '0;
              if (s_tlast && s_tdata == MARKER) begin
                state     <= ISSUE;
                s_tready  <= 1'b0;
                cnt       <= '0;
                cmd_vld_o <= 1'b1;
                cmd_dir_o <= frame[54];
                cmd_cmd_o <= frame[53:52];
                cmd_tag_o <= frame[51:48];
                cmd_val_o <= {frame[39:32], frame[47:40]};
                cmd_lun_o <= frame[7:4];
                cmd_adr_o <= {frame[3:0], frame[15:8], frame[23:16], frame[31:24]};
              end else if (!s_tlast) begin
                state <= DROP;
              end
            end else if (s_tlast) begin
              idx <= '0;
            end else begin
              frame <= {frame[FRAME_W-9:0], s_tdata};
              idx   <= idx + IDX_W'(1);
            end
          end
        end

        DROP: begin
          s_tready <= 1'b1;
          if (beat_c && s_tlast) state <= RECV;
        end

        ISSUE: begin
          s_tready <= 1'b0;
          if (status_c != 3'b000) begin
            state     <= SEND;
            cnt       <= '0;
            idx       <= '0;
            cmd_vld_o <= 1'b0;
            m_tvalid  <= 1'b1;
            m_tlast   <= 1'b0;
            m_tdata   <= {cmd_tag_o, 1'b0, status_c};
            rdata     <= (cmd_dir_o && status_c == ST_OK) ? cmd_val_i : 16'h0000;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        SEND: begin
          s_tready <= 1'b0;
          if (m_tvalid && m_tready) begin
            idx <= idx + IDX_W'(1);
            case (idx)
              IDX_W'(0): m_tdata <= rdata[7:0];
              IDX_W'(1): m_tdata <= rdata[15:8];
              IDX_W'(2): begin
                m_tdata <= 8'h00;
                m_tlast <= 1'b1;
              end
              default: begin
                state     <= RECV;
                idx       <= '0;
                m_tvalid  <= 1'b0;
                m_tlast   <= 1'b0;
                m_tdata   <= 8'h00;
                cmd_ack_o <= 1'b1;
                s_tready  <= 1'b1;
              end
            endcase
          end
        end

        default: state <= RECV;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_parser.sv
// Self-checking bench for cmd_parser: directed and random command frames
// compared against a frame/response model built from the byte-level format.
module tb_cmd_parser;

  localparam int unsigned WR_WAIT = 64;
  localparam int unsigned TIMEOUT = 1024;

  typedef logic [7:0] bq_t[$];

  logic        cmd_clk = 1'b0;
  logic        areset_n, cmd_rst;
  logic        s_tvalid, s_tlast, s_tready;
  logic [7:0]  s_tdata;
  logic        m_tvalid, m_tlast, m_tready;
  logic [7:0]  m_tdata;
  logic        cmd_vld_o, cmd_ack_o, cmd_dir_o;
  logic [1:0]  cmd_cmd_o;
  logic [3:0]  cmd_tag_o, cmd_lun_o;
  logic [15:0] cmd_val_o;
  logic [27:0] cmd_adr_o;
  logic        cmd_rdy_i, cmd_err_i;
  logic [15:0] cmd_val_i;

  int checks = 0;
  int failures = 0;

  cmd_parser #(.WR_WAIT(WR_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .areset_n(areset_n), .cmd_clk(cmd_clk), .cmd_rst(cmd_rst),
    .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready), .m_tdata(m_tdata),
    .cmd_vld_o(cmd_vld_o), .cmd_ack_o(cmd_ack_o), .cmd_dir_o(cmd_dir_o),
    .cmd_cmd_o(cmd_cmd_o), .cmd_tag_o(cmd_tag_o), .cmd_lun_o(cmd_lun_o),
    .cmd_val_o(cmd_val_o), .cmd_adr_o(cmd_adr_o),
    .cmd_rdy_i(cmd_rdy_i), .cmd_err_i(cmd_err_i), .cmd_val_i(cmd_val_i)
  );

  always #5 cmd_clk = ~cmd_clk;

  logic [71:0] all_out;
  assign all_out = {4'h0, s_tready, m_tvalid, m_tlast, m_tdata, cmd_vld_o, cmd_ack_o,
                    cmd_dir_o, cmd_cmd_o, cmd_tag_o, cmd_lun_o, cmd_val_o, cmd_adr_o};

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cmd_clk);
    #1;
  endtask

  function automatic bq_t mk_frame(input logic [7:0] b0, input logic [15:0] v,
                                   input logic [31:0] w, input logic [7:0] mk);
    bq_t q;
    q = {b0, v[7:0], v[15:8], w[7:0], w[15:8], w[23:16], w[31:24], mk};
    return q;
  endfunction

  task automatic send_frame(input bq_t q);
    for (int i = 0; i < q.size(); i++) begin
      int wt;
      s_tdata  = q[i];
      s_tlast  = (i == q.size() - 1);
      s_tvalid = 1'b1;
      wt = 0;
      while (!s_tready && wt < 100) begin tick(); wt++; end
      if (!s_tready) chk("s_tready_wait", 72'(s_tready), 72'(1));
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // kind: 0 = no reply, 1 = rdy, 2 = err, 3 = rdy and err together; reply driven at issue cycle k.
  task automatic do_issue(input logic [7:0] b0, input logic [15:0] v, input logic [31:0] w,
                          input int kind, input int k, input logic [15:0] rd,
                          output logic [7:0] e0, output logic [7:0] e1, output logic [7:0] e2);
    int dir, limit, n_exp, st, c;
    logic [15:0] rexp;
    dir   = (int'(b0) >> 6) & 1;
    limit = dir ? TIMEOUT : WR_WAIT;
    if ((kind == 2 || kind == 3) && k < limit) begin n_exp = k + 1; st = 2; end
    else if (dir == 1 && kind == 1 && k < limit) begin n_exp = k + 1; st = 1; end
    else if (dir == 0) begin n_exp = WR_WAIT; st = 1; end
    else begin n_exp = TIMEOUT; st = 4; end
    rexp = (dir == 1 && st == 1) ? rd : 16'h0000;
    e0 = 8'((int'(b0) % 16) * 16 + st);
    e1 = rexp[7:0];
    e2 = rexp[15:8];

    cmd_val_i = rd;
    send_frame(mk_frame(b0, v, w, 8'hA5));
    chk("vld_rise", 72'(cmd_vld_o), 72'(1));
    chk("s_tready_issue", 72'(s_tready), 72'(0));
    chk("dir", 72'(cmd_dir_o), 72'(dir));
    chk("cmd", 72'(cmd_cmd_o), 72'((int'(b0) / 16) % 4));
    chk("tag", 72'(cmd_tag_o), 72'(int'(b0) % 16));
    chk("val", 72'(cmd_val_o), 72'(v));
    chk("lun", 72'(cmd_lun_o), 72'(w / 32'h1000_0000));
    chk("adr", 72'(cmd_adr_o), 72'(w % 32'h1000_0000));
    c = 0;
    while (cmd_vld_o && c < 2 * TIMEOUT) begin
      cmd_rdy_i = (c == k) && (kind == 1 || kind == 3);
      cmd_err_i = (c == k) && (kind == 2 || kind == 3);
      tick();
      c++;
    end
    cmd_rdy_i = 1'b0;
    cmd_err_i = 1'b0;
    chk("vld_len", 72'(c), 72'(n_exp));
    chk("m_tvalid_rise", 72'(m_tvalid), 72'(1));
  endtask

  // bp: 0 = always ready, 1 = toggle every cycle, 2 = random
  task automatic do_resp(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                         input int bp);
    logic [7:0] ex[4];
    int i, cyc;
    logic hs;
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = 8'h00;
    i = 0; cyc = 0;
    m_tready = (bp == 1) ? 1'b0 : 1'b1;
    while (i < 4 && cyc < 200) begin
      if (bp == 1) m_tready = ~m_tready;
      else if (bp == 2) m_tready = 1'($urandom_range(0, 1));
      chk("resp_valid", 72'(m_tvalid), 72'(1));
      chk("resp_data", 72'(m_tdata), 72'(ex[i]));
      chk("resp_last", 72'(m_tlast), 72'(i == 3));
      chk("ack_early", 72'(cmd_ack_o), 72'(0));
      hs = m_tvalid && m_tready;
      tick();
      cyc++;
      if (hs) i++;
    end
    chk("resp_bytes", 72'(i), 72'(4));
    chk("ack_pulse", 72'(cmd_ack_o), 72'(1));
    chk("m_tvalid_drop", 72'(m_tvalid), 72'(0));
    m_tready = 1'b1;
    tick();
    chk("ack_single", 72'(cmd_ack_o), 72'(0));
    chk("ready_after", 72'(s_tready), 72'(1));
  endtask

  task automatic run_txn(input logic [7:0] b0, input logic [15:0] v, input logic [31:0] w,
                         input int kind, input int k, input logic [15:0] rd, input int bp);
    logic [7:0] e0, e1, e2;
    do_issue(b0, v, w, kind, k, rd, e0, e1, e2);
    do_resp(e0, e1, e2, bp);
  endtask

  task automatic expect_idle(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk(tag, 72'(cmd_vld_o), 72'(0));
      tick();
    end
    chk("idle_ready", 72'(s_tready), 72'(1));
  endtask

  initial begin
    bq_t q, q5;
    logic [7:0] e0, e1, e2;
    areset_n = 1'b0; cmd_rst = 1'b0;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00;
    m_tready = 1'b1; cmd_rdy_i = 1'b0; cmd_err_i = 1'b0; cmd_val_i = 16'h0000;
    #2;
    chk("reset_outputs", all_out, 72'(0));
    tick(); tick();
    chk("reset_held", all_out, 72'(0));
    areset_n = 1'b1;
    tick();
    chk("ready_first_edge", 72'(s_tready), 72'(1));

    // Directed read with data, write, read error, read timeout
    run_txn(8'h53, 16'h0000, 32'h2000_0010, 1, 3, 16'hBEEF, 0);
    run_txn(8'h07, 16'h1234, 32'h0000_0000, 0, 0, 16'h5555, 0);
    run_txn(8'h4A, 16'h0000, 32'h1234_5678, 2, 5, 16'h7777, 0);
    run_txn(8'h5C, 16'h0000, 32'h0000_0100, 0, 0, 16'h9999, 0);
    // rdy and err together reports error
    run_txn(8'h41, 16'hAAAA, 32'hF000_0001, 3, 2, 16'h1111, 1);
    // rdy on a write is ignored; write still waits full period
    run_txn(8'h32, 16'hCAFE, 32'h0ABC_DEF0, 1, 4, 16'h2222, 1);

    // Short frame: tlast on byte 4, then a good frame
    q = mk_frame(8'h46, 16'h0101, 32'h1000_0002, 8'hA5);
    q5 = q[0:4];
    send_frame(q5);
    expect_idle("short_no_vld");
    run_txn(8'h46, 16'h0101, 32'h1000_0002, 1, 0, 16'h0F0F, 2);
    // Ten-byte frame goes through DROP without issue
    q = mk_frame(8'h48, 16'h0000, 32'h0000_0000, 8'hA5);
    q.push_back(8'hA5);
    q.push_back(8'h11);
    send_frame(q);
    expect_idle("long_no_vld");
    // Bad marker
    send_frame(mk_frame(8'h48, 16'h0000, 32'h0000_0000, 8'h5A));
    expect_idle("bad_marker_no_vld");

    // Async reset mid-SEND abandons the response
    do_issue(8'h5D, 16'h0000, 32'h3000_0040, 1, 1, 16'h4242, e0, e1, e2);
    m_tready = 1'b0;
    tick();
    chk("send_stall_valid", 72'(m_tvalid), 72'(1));
    areset_n = 1'b0;
    #1;
    chk("async_reset_outputs", all_out, 72'(0));
    tick();
    chk("async_reset_held", all_out, 72'(0));
    areset_n = 1'b1;
    m_tready = 1'b1;
    tick();
    chk("post_reset_ready", 72'(s_tready), 72'(1));
    chk("post_reset_no_resp", 72'(m_tvalid), 72'(0));
    tick();
    chk("post_reset_no_ack", 72'(cmd_ack_o), 72'(0));
    run_txn(8'h59, 16'h0000, 32'h0000_0008, 1, 7, 16'h8001, 1);

    // Sync reset during ISSUE
    send_frame(mk_frame(8'h4E, 16'h0000, 32'h0000_0000, 8'hA5));
    chk("issue_before_rst", 72'(cmd_vld_o), 72'(1));
    tick();
    cmd_rst = 1'b1;
    tick();
    chk("sync_reset_outputs", all_out, 72'(0));
    cmd_rst = 1'b0;
    tick();
    chk("sync_post_ready", 72'(s_tready), 72'(1));
    chk("sync_no_resp", 72'(m_tvalid), 72'(0));

    // Random transactions
    for (int t = 0; t < 12; t++) begin
      logic [7:0] b0;
      int kind;
      b0 = 8'($urandom);
      kind = $urandom_range(0, 3);
      if (((int'(b0) >> 6) & 1) == 1 && kind == 0) kind = 1;
      run_txn(b0, 16'($urandom), $urandom, kind, $urandom_range(0, 79),
              16'($urandom), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
